// File: rtl/mem_ctrl.sv
// Single-port 64-bit word memory behind a request/response FIFO pair; READ data appears one cycle after issue.
// The request pop strobe is mem_req_rd_en, registered one cycle after almost_full. READs already popped are still pushed.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_req_rd_cmd,
  input  logic [21:0] mem_req_rd_addr,
  input  logic [63:0] mem_req_rd_dta,
  output logic        mem_req_rd_en,
  input  logic        mem_req_rd_valid,
  output logic [63:0] mem_res_wr_dta,
  output logic        mem_res_wr_en,
  input  logic        mem_res_wr_almost_full
);

  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  logic [63:0]           r_mem [0:(2**ADDR_WIDTH)-1];
  logic                  r_req_rd_en;
  logic                  r_res_wr_en;
  logic [63:0]           r_res_wr_dta;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_rd;
  logic                  w_wr;

  // Upper address bits are dropped so accesses wrap over the implemented depth.
  assign w_addr = mem_req_rd_addr[ADDR_WIDTH-1:0];
  assign w_rd   = rst && mem_req_rd_valid && (mem_req_rd_cmd == CMD_READ);
  assign w_wr   = rst && mem_req_rd_valid && (mem_req_rd_cmd == CMD_WRITE);

  generate
    if (ADDR_WIDTH < 22) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^mem_req_rd_addr[21:ADDR_WIDTH];
    end
  endgenerate

  // Storage has no reset so it maps onto a plain RAM and survives rst.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_addr] <= mem_req_rd_dta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req_rd_en  <= 1'b0;
      r_res_wr_en  <= 1'b0;
      r_res_wr_dta <= 64'd0;
    end else begin
      r_req_rd_en <= !mem_res_wr_almost_full;
      r_res_wr_en <= w_rd;
      if (w_rd) begin
        r_res_wr_dta <= r_mem[w_addr];
      end
    end
  end

  assign mem_req_rd_en  = r_req_rd_en;
  assign mem_res_wr_en  = r_res_wr_en;
  assign mem_res_wr_dta = r_res_wr_dta;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized + directed bench for mem_ctrl with a queue-based response scoreboard.
module tb_mem_ctrl;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [21:0] addr = 22'd0;
  logic [63:0] dta = 64'd0;
  logic        valid = 1'b0;
  logic        af = 1'b0;
  logic        rd_en;
  logic [63:0] res_dta;
  logic        res_en;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;
  exp_t q[$];

  logic [63:0] model [DEPTH];
  bit          written [DEPTH];
  bit          exp_en = 1'b0;
  bit          rst_s = 1'b0;
  logic [63:0] exp_last = 64'd0;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_req_rd_cmd         (cmd),
    .mem_req_rd_addr        (addr),
    .mem_req_rd_dta         (dta),
    .mem_req_rd_en          (rd_en),
    .mem_req_rd_valid       (valid),
    .mem_res_wr_dta         (res_dta),
    .mem_res_wr_en          (res_en),
    .mem_res_wr_almost_full (af)
  );

  always #5 clk = ~clk;

  // Reference timing: pop strobe follows the previous edge's rst/almost_full.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    exp_en <= rst && !af;
    rst_s  <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("rd_en", {63'd0, rd_en}, {63'd0, exp_en});
      if (!rst_s) exp_last = 64'd0;
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("missed_response", 64'd0, 64'd1);
        void'(q.pop_front());
      end
      if (res_en) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          chk("unexpected_response", 64'd1, 64'd0);
          exp_last = res_dta;
        end else begin
          chk("read_data", res_dta, q[0].d);
          exp_last = q[0].d;
          void'(q.pop_front());
        end
      end else begin
        chk("hold_data", res_dta, exp_last);
      end
    end
  end

  task automatic drive(input logic r, input logic a_f, input logic v, input logic [1:0] c,
                       input logic [21:0] ad, input logic [63:0] d);
    int idx;
    exp_t e;
    @(negedge clk);
    rst = r; af = a_f; valid = v; cmd = c; addr = ad; dta = d;
    idx = int'(ad) % DEPTH;
    if (r && v && c == 2'd3) begin
      model[idx]   = d;
      written[idx] = 1'b1;
    end
    if (r && v && c == 2'd2) begin
      e.d   = model[idx];
      e.due = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 2'd0, 22'd0, 64'd0);
  endtask

  initial begin
    logic [1:0]  rc;
    logic [21:0] ra;
    // Reset held 8 cycles; commands offered meanwhile must be ignored.
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 2'd3, 22'h10, 64'hDEAD_BEEF_0000_0000 + 64'(i));
    drive(1'b0, 1'b0, 1'b1, 2'd2, 22'h10, 64'd0);
    idle(2);

    drive(1'b1, 1'b0, 1'b1, 2'd3, 22'h000010, 64'h0123456789ABCDEF);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 22'h000010, 64'd0);
    idle(1);

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 2'd3, 22'(i), 64'hA0 + 64'(i));
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 2'd2, 22'(i), 64'd0);
    idle(2);

    drive(1'b1, 1'b0, 1'b1, 2'd0, 22'h10, 64'hFFFF);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 22'h10, 64'hFFFF);
    idle(2);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 22'h10, 64'd0);
    idle(1);

    // Backpressure: a READ accepted alongside almost_full is still answered.
    drive(1'b1, 1'b1, 1'b1, 2'd2, 22'h1, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 22'h0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 22'h0, 64'd0);
    idle(2);

    drive(1'b1, 1'b0, 1'b1, 2'd3, 22'h000405, 64'h55);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 22'h000005, 64'd0);
    idle(1);

    // Mid-operation reset: READ and WRITE under reset are dropped, storage kept.
    drive(1'b1, 1'b0, 1'b1, 2'd3, 22'h20, 64'hCAFE_F00D_1234_5678);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 22'h20, 64'd0);
    drive(1'b0, 1'b0, 1'b1, 2'd2, 22'h20, 64'd0);
    drive(1'b0, 1'b0, 1'b1, 2'd3, 22'h20, 64'h1111);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 22'h20, 64'd0);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 22'h10, 64'd0);
    idle(2);

    for (int i = 0; i < 800; i++) begin
      rc = 2'($urandom_range(0, 3));
      ra = 22'($urandom);
      if (rc == 2'd2 && !written[int'(ra) % DEPTH]) rc = 2'd3;
      drive(($urandom_range(0, 60) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0), rc, ra, {$urandom, $urandom});
    end
    idle(4);
    if (q.size() != 0) chk("leftover_expected", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
